// File: rtl/ram_clr_dp.sv
// Dual-port byte-writable RAM with a self-sequencing clear engine (busy while zeroing).
// Define RAM_FWD_EN to forward same-address write data into a concurrent read.
module ram_clr_dp #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int RD_PIPE    = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_enb,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic                    rd_enb,
   input  logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_valid,
   input  logic                    clr_req,
   output logic                    busy,
   output logic                    dbg_state
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int NB    = DATA_WIDTH / 8;

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic                    wr_acc, rd_acc;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic                    rd_v1_q;
   logic [DATA_WIDTH-1:0]   rd_d1_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            // Counter parks on the last address rather than wrapping.
            if (cnt_q == '1) state_d = IDLE;
            else             cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy      = (state_q == CLEAR);
   assign dbg_state = state_q;

   // Requests only count in IDLE and never in the cycle that launches a clear.
   assign wr_acc = !rst && (state_q == IDLE) && !clr_req && wr_enb;
   assign rd_acc = !rst && (state_q == IDLE) && !clr_req && rd_enb;

   always_ff @(posedge clk) begin
      if (!rst && state_q == CLEAR) begin
         mem[cnt_q] <= '0;
      end else if (wr_acc) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   always_comb begin
      rd_word = mem[rd_addr];
`ifdef RAM_FWD_EN
      if (wr_acc && (wr_addr == rd_addr)) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
         end
      end
`else
`endif
   end

   // Data registers only load on a result so the output holds between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_v1_q <= 1'b0;
         rd_d1_q <= '0;
      end else begin
         rd_v1_q <= rd_acc;
         if (rd_acc) rd_d1_q <= rd_word;
      end
   end

   generate
      if (RD_PIPE == 0) begin : gen_pipe0
         assign rd_data  = rd_d1_q;
         assign rd_valid = rd_v1_q;
      end else begin : gen_pipe1
         logic                  rd_v2_q;
         logic [DATA_WIDTH-1:0] rd_d2_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               rd_v2_q <= 1'b0;
               rd_d2_q <= '0;
            end else begin
               rd_v2_q <= rd_v1_q;
               if (rd_v1_q) rd_d2_q <= rd_d1_q;
            end
         end
         assign rd_data  = rd_d2_q;
         assign rd_valid = rd_v2_q;
      end
   endgenerate

endmodule

// File: tb/tb_ram_clr_dp.sv
// Directed bench for ram_clr_dp: one instance with 1-cycle and one with 2-cycle read
// latency share all inputs; each step compares against hand-computed values.
module tb_ram_clr_dp;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_enb, rd_enb, clr_req;
   logic [3:0]  wr_addr, rd_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic [31:0] rd_data0, rd_data1;
   logic        rd_valid0, rd_valid1, busy0, busy1, dbg0, dbg1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_clr_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_PIPE(0)) dut0 (
      .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data0),
      .rd_valid(rd_valid0), .clr_req(clr_req), .busy(busy0), .dbg_state(dbg0)
   );

   ram_clr_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_PIPE(1)) dut1 (
      .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data1),
      .rd_valid(rd_valid1), .clr_req(clr_req), .busy(busy1), .dbg_state(dbg1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_enb = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      step();
      wr_enb = 1'b0;
   endtask

   task automatic do_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
      rd_enb = 1'b1; rd_addr = a;
      step();
      rd_enb = 1'b0;
      chk({tag, "_v0"}, rd_valid0, 1);
      chk({tag, "_d0"}, rd_data0, exp);
      chk({tag, "_v1_early"}, rd_valid1, 0);
      step();
      chk({tag, "_v0_gone"}, rd_valid0, 0);
      chk({tag, "_v1"}, rd_valid1, 1);
      chk({tag, "_d1"}, rd_data1, exp);
   endtask

   // Steps until busy drops (bounded) and checks the number of busy cycles.
   task automatic wait_clear(input string tag, output logic any_v);
      int n = 0;
      any_v = 1'b0;
      while (busy0 && n < 100) begin
         step();
         n++;
         any_v = any_v | rd_valid0 | rd_valid1;
      end
      chk({tag, "_busy_cycles"}, n, 16);
      chk({tag, "_busy1"}, busy1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic        any_v;
      logic [31:0] exp_rdw;
      rst = 1'b1; wr_enb = 1'b0; rd_enb = 1'b0; clr_req = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
      step(); step();
      chk("rst_valid0", rd_valid0, 0);
      chk("rst_valid1", rd_valid1, 0);
      chk("rst_data0", rd_data0, 0);
      chk("rst_data1", rd_data1, 0);
      chk("rst_busy0", busy0, 1);
      chk("rst_busy1", busy1, 1);
      chk("rst_state", dbg0, 1);

      rst = 1'b0;
      wait_clear("init", any_v);
      chk("init_state_idle", dbg0, 0);
      do_read("init_rd7", 4'd7, 32'h0000_0000);

      // Partial byte-enable merge.
      do_write(4'd3, 32'hDEAD_BEEF, 4'hF);
      do_write(4'd3, 32'h1122_3344, 4'b0101);
      do_read("merge_rd3", 4'd3, 32'hDE22_BE44);

      // Write and read of different addresses in one cycle.
      wr_enb = 1'b1; wr_addr = 4'd9; wr_data = 32'h1234_5678; wr_be = 4'hF;
      wr_enb = 1'b1;
      rd_enb = 1'b1; rd_addr = 4'd3;
      step();
      wr_enb = 1'b0; rd_enb = 1'b0;
      chk("diff_v0", rd_valid0, 1);
      chk("diff_d0", rd_data0, 32'hDE22_BE44);
      step();
      chk("diff_d1", rd_data1, 32'hDE22_BE44);
      do_read("diff_rd9", 4'd9, 32'h1234_5678);

      // Same-address read during write.
      do_write(4'd5, 32'hAAAA_AAAA, 4'hF);
`ifdef RAM_FWD_EN
      exp_rdw = 32'h5555_5555;
`else
      exp_rdw = 32'hAAAA_AAAA;
`endif
      wr_enb = 1'b1; wr_addr = 4'd5; wr_data = 32'h5555_5555; wr_be = 4'hF;
      rd_enb = 1'b1; rd_addr = 4'd5;
      step();
      wr_enb = 1'b0; rd_enb = 1'b0;
      chk("rdw_d0", rd_data0, exp_rdw);
      step();
      chk("rdw_d1", rd_data1, exp_rdw);
      do_read("rdw_after", 4'd5, 32'h5555_5555);

      // Fill with address values, then back-to-back reads of 0,1,2.
      for (int i = 0; i < 16; i++) do_write(4'(i), 32'(i), 4'hF);
      rd_enb = 1'b1; rd_addr = 4'd0;
      step();
      chk("b2b_c1_v0", rd_valid0, 1);
      chk("b2b_c1_d0", rd_data0, 0);
      rd_addr = 4'd1;
      step();
      chk("b2b_c2_d0", rd_data0, 1);
      chk("b2b_c2_v1", rd_valid1, 1);
      chk("b2b_c2_d1", rd_data1, 0);
      rd_addr = 4'd2;
      step();
      chk("b2b_c3_d0", rd_data0, 2);
      chk("b2b_c3_v1", rd_valid1, 1);
      chk("b2b_c3_d1", rd_data1, 1);
      rd_enb = 1'b0;
      step();
      chk("b2b_c4_v0", rd_valid0, 0);
      chk("b2b_c4_hold0", rd_data0, 2);
      chk("b2b_c4_v1", rd_valid1, 1);
      chk("b2b_c4_d1", rd_data1, 2);
      step();
      chk("b2b_c5_v1", rd_valid1, 0);
      chk("b2b_c5_hold1", rd_data1, 2);

      // Read accepted just before a clear, then requests hammered during busy.
      rd_enb = 1'b1; rd_addr = 4'd4;
      step();
      chk("pre_clr_v0", rd_valid0, 1);
      chk("pre_clr_d0", rd_data0, 4);
      clr_req = 1'b1; rd_addr = 4'd6;
      wr_enb = 1'b1; wr_addr = 4'd6; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
      step();
      chk("clr_start_busy", busy0, 1);
      chk("clr_start_v0", rd_valid0, 0);
      chk("clr_start_v1", rd_valid1, 1);
      chk("clr_start_d1", rd_data1, 4);
      wait_clear("clr", any_v);
      clr_req = 1'b0; rd_enb = 1'b0; wr_enb = 1'b0;
      chk("clr_no_valid", any_v, 0);
      do_read("clr_rd4", 4'd4, 0);
      do_read("clr_rd6", 4'd6, 0);
      do_read("clr_rd15", 4'd15, 0);

      // Reset at clear cycle 7 restarts the full sequence.
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      for (int i = 0; i < 6; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midclr_busy", busy0, 1);
      wait_clear("midclr", any_v);

      // Reset while a 2-cycle read is in flight.
      do_write(4'd2, 32'h0000_0077, 4'hF);
      rd_enb = 1'b1; rd_addr = 4'd2;
      step();
      rd_enb = 1'b0;
      chk("flight_v0", rd_valid0, 1);
      chk("flight_d0", rd_data0, 32'h77);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("flight_v1_killed", rd_valid1, 0);
      chk("flight_d1_zero", rd_data1, 0);
      chk("flight_d0_zero", rd_data0, 0);
      wait_clear("flight", any_v);
      chk("flight_no_valid", any_v, 0);
      do_read("flight_rd2", 4'd2, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
